// File: rtl/fetch_buffer.sv
// Fetch buffer: registers fetch requests, queues {pc, instr} responses for decode.
// Optional same-cycle bypass into decode when empty: FETCH_BUF_BYPASS_EN.
module fetch_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [XLEN-1:0]          pc,
  input  logic                     instr_read_en,
  input  logic                     branch_taken,
  input  logic [XLEN-1:0]          instr_rdata,
  output logic                     fetch_halt,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [XLEN-1:0]          id_instr,
  output logic [XLEN-1:0]          id_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     occ_q, occ_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic   byp;
  logic   push;
  logic   pop;
  entry_t rsp;
  entry_t head;
  logic [AW+1:0] pend;

  always_comb begin
    rsp = '{pc: req_pc_q, instr: instr_rdata};
`ifdef FETCH_BUF_BYPASS_EN
    byp = (occ_q == '0) && req_valid_q && !branch_taken;
`else
    byp = 1'b0;
`endif
    head     = byp ? rsp : mem_q[rd_ptr_q];
    id_valid = !branch_taken && ((occ_q != '0) || byp);
    pop      = id_valid && id_ready && !byp;
    // a bypassed response that decode takes never touches the array
    push     = req_valid_q && !branch_taken && !(byp && id_ready);
    id_instr = id_valid ? head.instr : '0;
    id_pc    = id_valid ? head.pc : '0;
  end

  // registered-only halt so fetch never sees a path from id_ready
  assign pend       = {1'b0, occ_q} + (AW+2)'(req_valid_q);
  assign fetch_halt = pend >= (AW+2)'(DEPTH);
  assign occupancy  = occ_q;

  always_comb begin
    req_valid_d = instr_read_en;
    req_pc_d    = instr_read_en ? pc : req_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    if (branch_taken) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      occ_d    = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= rsp;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: outstanding requests kept as a queue
// tagged with issue cycle; decode visibility derived from request age.
module tb_fetch_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef FETCH_BUF_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] pc = '0;
  logic            instr_read_en = 1'b0;
  logic            branch_taken = 1'b0;
  logic [XLEN-1:0] instr_rdata = '0;
  logic            fetch_halt;
  logic            id_valid;
  logic            id_ready = 1'b0;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [2:0]      occupancy;

  fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .instr_read_en(instr_read_en), .branch_taken(branch_taken),
    .instr_rdata(instr_rdata), .fetch_halt(fetch_halt),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    int              cyc;
  } req_t;

  req_t            exp_q[$];
  int              cyc = 0;
  int              n_cmp = 0;
  int              n_err = 0;
  logic            prev_rd = 1'b0;
  logic [XLEN-1:0] prev_pc = '0;
  logic [XLEN-1:0] next_pc = '0;

  always @(posedge clk) cyc++;

  function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return (a << 5) + 32'h13;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rd, input logic [XLEN-1:0] p,
                      input logic br, input logic rdy);
    @(posedge clk);
    #1;
    instr_rdata   = prev_rd ? mem_word(prev_pc) : $urandom;
    prev_rd       = rd && (br || !fetch_halt);
    prev_pc       = p;
    instr_read_en = prev_rd;
    pc            = p;
    branch_taken  = br;
    id_ready      = rdy;
    if (prev_rd) begin
      exp_q.push_back('{pc: p, cyc: cyc});
      next_pc = p + 4;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      int   aged;
      int   pend;
      logic ev;
      aged = 0;
      pend = 0;
      foreach (exp_q[i]) begin
        if (cyc - exp_q[i].cyc >= 2) aged++;
        if (cyc - exp_q[i].cyc >= 1) pend++;
      end
      ev = !branch_taken && exp_q.size() > 0 && (cyc - exp_q[0].cyc) >= LAT;
      chk("id_valid", id_valid, ev);
      chk("occupancy", occupancy, aged);
      chk("fetch_halt", fetch_halt, pend >= DEPTH);
      chk("no_push_full", occupancy <= DEPTH, 1);
      if (ev) begin
        chk("id_pc", id_pc, exp_q[0].pc);
        chk("id_instr", id_instr, mem_word(exp_q[0].pc));
        if (id_ready) void'(exp_q.pop_front());
      end else begin
        chk("id_pc_idle", id_pc, 0);
        chk("id_instr_idle", id_instr, 0);
      end
      // a redirect kills every request older than this cycle
      if (branch_taken)
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, id_valid, 0);
    chk({tag, "_instr"}, id_instr, 0);
    chk({tag, "_pc"}, id_pc, 0);
    chk({tag, "_halt"}, fetch_halt, 0);
    chk({tag, "_occ"}, occupancy, 0);
  endtask

  initial begin
    logic            br;
    logic [XLEN-1:0] p;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    #1 rst_n = 1'b1;

    // streaming
    step(1, 32'h0, 0, 1);
    step(1, 32'h4, 0, 1);
    step(1, 32'h8, 0, 1);
    repeat (4) step(0, 0, 0, 1);

    // fill with decode stalled
    for (int i = 0; i < 7; i++) step(1, 32'(i * 4), 0, 0);
    #1;
    chk("full_occ", occupancy, 4);
    chk("full_halt", fetch_halt, 1);
    chk("full_head", id_pc, 0);

    // single pop then refill
    step(0, 0, 0, 1);
    step(1, 32'h10, 0, 0);
    #1;
    chk("drain_occ", occupancy, 3);
    chk("drain_halt", fetch_halt, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    #1;
    chk("refill_occ", occupancy, 4);
    chk("refill_halt", fetch_halt, 1);

    // flush with three stored and one in flight
    repeat (6) step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 32'(32'h20 + i * 4), 0, 0);
    step(1, 32'h100, 1, 0);
    #1;
    chk("flush_valid", id_valid, 0);
    step(0, 0, 0, 0);
    #1;
    chk("flush_occ", occupancy, 0);
    step(0, 0, 0, 1);
    #1;
    chk("target_valid", id_valid, 1);
    chk("target_pc", id_pc, 32'h100);

    // simultaneous push and pop
    repeat (3) step(0, 0, 0, 1);
    step(1, 32'h40, 0, 0);
    step(1, 32'h44, 0, 0);
    step(1, 32'h48, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    #1;
    chk("pp_occ", occupancy, 2);
    chk("pp_head", id_pc, 32'h44);

    // asynchronous reset mid-stream
    step(1, 32'h4c, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    #1;
    chk("pre_rst_occ", occupancy, 3);
    @(posedge clk);
    #1;
    instr_read_en = 1'b0;
    branch_taken  = 1'b0;
    id_ready      = 1'b0;
    instr_rdata   = $urandom;
    prev_rd       = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_zero("midrst");
    exp_q.delete();
    #1 rst_n = 1'b1;
    step(1, 32'h200, 0, 1);
    repeat (3) step(0, 0, 0, 1);

    // randomized traffic
    next_pc = 32'h300;
    for (int i = 0; i < 500; i++) begin
      br = ($urandom_range(0, 15) == 0);
      p  = br ? 32'h1000 + 32'($urandom_range(0, 255)) * 4 : next_pc;
      step(br | ($urandom_range(0, 3) != 0), p, br, $urandom_range(0, 9) < 6);
    end
    repeat (10) step(0, 0, 0, 1);

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
